// File: rtl/padartha_dispatch_arbiter.sv
// Round-robin dispatcher: grants one of four requesters, issues its object to the
// classifier, waits with a hang timeout, returns the result, and manages the paramanu lock.
module padartha_dispatch_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*8-1:0]          req_id,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         eng_object_data,
  output logic [7:0]                    eng_object_id,
  output logic                          eng_object_valid,
  input  logic                          eng_classified,
  input  logic [2:0]                    eng_padartha,
  input  logic [3:0]                    eng_certainty,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [2:0]                    rsp_padartha,
  output logic [3:0]                    rsp_certainty,
  output logic                          atomic_owner_valid,
  output logic [1:0]                    atomic_owner,
  output logic                          timeout_err,
  output logic                          busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] ABHAVA = 3'd6;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t          state_q, state_d;
  logic [1:0]      rr_ptr_q;
  logic [1:0]      winner_q;
  logic [CW-1:0]   cnt_q;
  logic            timed_out_q;
  logic [3:0]      eligible;
  logic            grant_found;
  logic [1:0]      grant_idx;
  logic [1:0]      arb_idx;
  logic            cnt_hit;
  logic [3:0]      cmd_nibble;

  assign cnt_hit    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cmd_nibble = eng_object_data[31:28];
  assign busy       = (state_q != IDLE);

  // While the lock is held only the owner may compete.
  always_comb begin
    eligible    = atomic_owner_valid ? (req_valid & (4'b0001 << atomic_owner)) : req_valid;
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    arb_idx     = rr_ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      arb_idx = rr_ptr_q + 2'(i);
      if (!grant_found && eligible[arb_idx]) begin
        grant_found = 1'b1;
        grant_idx   = arb_idx;
      end
    end
  end

  // Pulse outputs are masked while rst is high so the block is silent during reset.
  always_comb begin
    state_d          = state_q;
    req_ready        = '0;
    eng_object_valid = 1'b0;
    rsp_valid        = '0;
    timeout_err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        eng_object_valid = !rst;
        state_d          = WAIT;
      end
      WAIT: begin
        if (eng_classified) begin
          state_d = RESPOND;
        end else if (cnt_hit) begin
          timeout_err = !rst;
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
        rsp_valid[winner_q] = !rst;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      rr_ptr_q           <= '0;
      winner_q           <= '0;
      cnt_q              <= '0;
      timed_out_q        <= 1'b0;
      eng_object_data    <= '0;
      eng_object_id      <= '0;
      rsp_padartha       <= ABHAVA;
      rsp_certainty      <= '0;
      atomic_owner_valid <= 1'b0;
      atomic_owner       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            winner_q        <= grant_idx;
            eng_object_data <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            eng_object_id   <= req_id[grant_idx*8 +: 8];
          end
        end
        ISSUE: begin
          cnt_q       <= '0;
          timed_out_q <= 1'b0;
        end
        WAIT: begin
          if (eng_classified) begin
            rsp_padartha  <= eng_padartha;
            rsp_certainty <= eng_certainty;
          end else if (cnt_hit) begin
            rsp_padartha  <= ABHAVA;
            rsp_certainty <= '0;
            timed_out_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESPOND: begin
          rr_ptr_q <= winner_q + 2'd1;
          // Release is honoured even after a timeout; acquire only on a real result.
          if (atomic_owner_valid && atomic_owner == winner_q && cmd_nibble == 4'h9) begin
            atomic_owner_valid <= 1'b0;
          end else if (!timed_out_q && !atomic_owner_valid && cmd_nibble == 4'hF) begin
            atomic_owner_valid <= 1'b1;
            atomic_owner       <= winner_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_padartha_dispatch_arbiter.sv
// Self-checking bench for padartha_dispatch_arbiter: directed scenarios plus random
// transactions compared against an abstract arbitration/lock model.
module tb_padartha_dispatch_arbiter;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_valid = '0;
  logic [4*DW-1:0] req_data;
  logic [31:0]   req_id;
  logic [3:0]    req_ready;
  logic [DW-1:0] eng_object_data;
  logic [7:0]    eng_object_id;
  logic          eng_object_valid;
  logic          eng_classified = 1'b0;
  logic [2:0]    eng_padartha = '0;
  logic [3:0]    eng_certainty = '0;
  logic [3:0]    rsp_valid;
  logic [2:0]    rsp_padartha;
  logic [3:0]    rsp_certainty;
  logic          atomic_owner_valid;
  logic [1:0]    atomic_owner;
  logic          timeout_err;
  logic          busy;

  logic [31:0] data_w [4];
  logic [7:0]  id_w   [4];

  assign req_data = {data_w[3], data_w[2], data_w[1], data_w[0]};
  assign req_id   = {id_w[3], id_w[2], id_w[1], id_w[0]};

  padartha_dispatch_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_id(req_id),
    .req_ready(req_ready), .eng_object_data(eng_object_data), .eng_object_id(eng_object_id),
    .eng_object_valid(eng_object_valid), .eng_classified(eng_classified),
    .eng_padartha(eng_padartha), .eng_certainty(eng_certainty), .rsp_valid(rsp_valid),
    .rsp_padartha(rsp_padartha), .rsp_certainty(rsp_certainty),
    .atomic_owner_valid(atomic_owner_valid), .atomic_owner(atomic_owner),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_rr    = 0;
  int m_lock  = 0;
  int m_owner = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] rv);
    logic [3:0] el;
    el = rv;
    if (m_lock != 0) begin
      el = '0;
      el[m_owner] = rv[m_owner];
    end
    for (int i = 0; i < 4; i++) begin
      if (el[(m_rr + i) % 4]) return (m_rr + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_data();
    logic [31:0] d;
    d = $urandom;
    case ($urandom_range(0, 3))
      0: d[31:28] = 4'hF;
      1: d[31:28] = 4'h9;
      default: ;
    endcase
    return d;
  endfunction

  task automatic do_reset();
    req_valid      = '0;
    eng_classified = 1'b0;
    rst            = 1'b1;
    @(negedge clk); #1;
    check("rst_ready_during", 64'(req_ready), 64'(0));
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_issue", 64'(eng_object_valid), 64'(0));
    check("rst_obj_data", 64'(eng_object_data), 64'(0));
    check("rst_obj_id", 64'(eng_object_id), 64'(0));
    check("rst_timeout", 64'(timeout_err), 64'(0));
    check("rst_owner_valid", 64'(atomic_owner_valid), 64'(0));
    check("rst_owner", 64'(atomic_owner), 64'(0));
    check("rst_padartha", 64'(rsp_padartha), 64'(6));
    check("rst_certainty", 64'(rsp_certainty), 64'(0));
    m_rr = 0; m_lock = 0; m_owner = 0;
  endtask

  // One full transaction; delay >= TO means the classifier never answers.
  task automatic txn(input logic [3:0] rv, input int delay, input logic [2:0] pad,
                     input logic [3:0] cert, output logic [3:0] got_ready);
    int w;
    int cyc;
    bit timed;
    bit exp_to;
    logic [3:0] top;
    req_valid     = rv;
    eng_padartha  = pad;
    eng_certainty = cert;
    #1;
    w = pick(rv);
    got_ready = req_ready;
    if (w < 0) begin
      check("ready_none", 64'(req_ready), 64'(0));
      @(negedge clk); #1;
      check("idle_stays", 64'(busy), 64'(0));
      return;
    end
    check("ready", 64'(req_ready), 64'(1) << w);
    check("busy_idle", 64'(busy), 64'(0));
    cyc = 0;
    timed = 0;
    @(negedge clk); cyc++;
    req_valid = 4'($urandom);
    #1;
    check("issue_valid", 64'(eng_object_valid), 64'(1));
    check("issue_data", 64'(eng_object_data), 64'(data_w[w]));
    check("issue_id", 64'(eng_object_id), 64'(id_w[w]));
    check("ready_clear", 64'(req_ready), 64'(0));
    check("busy_issue", 64'(busy), 64'(1));
    for (int k = 0; k < TO; k++) begin
      @(negedge clk); cyc++;
      eng_classified = (k == delay);
      req_valid = 4'($urandom);
      #1;
      exp_to = !eng_classified && (k == TO - 1);
      check("wait_no_issue", 64'(eng_object_valid), 64'(0));
      check("wait_hold_data", 64'(eng_object_data), 64'(data_w[w]));
      check("wait_hold_id", 64'(eng_object_id), 64'(id_w[w]));
      check("timeout", 64'(timeout_err), 64'(exp_to));
      check("wait_rsp", 64'(rsp_valid), 64'(0));
      if (eng_classified) break;
      if (exp_to) begin
        timed = 1;
        break;
      end
    end
    @(negedge clk); cyc++;
    eng_classified = 1'b0;
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(1) << w);
    check("rsp_padartha", 64'(rsp_padartha), timed ? 64'(6) : 64'(pad));
    check("rsp_certainty", 64'(rsp_certainty), timed ? 64'(0) : 64'(cert));
    check("rsp_timeout", 64'(timeout_err), 64'(0));
    check("turnaround", 64'(cyc), timed ? 64'(TO + 2) : 64'(delay + 3));
    m_rr = (w + 1) % 4;
    top = data_w[w][31:28];
    if (m_lock != 0 && m_owner == w && top == 4'h9) m_lock = 0;
    else if (!timed && m_lock == 0 && top == 4'hF) begin
      m_lock = 1;
      m_owner = w;
    end
    @(negedge clk); #1;
    check("post_busy", 64'(busy), 64'(0));
    check("post_rsp", 64'(rsp_valid), 64'(0));
    check("owner_valid", 64'(atomic_owner_valid), 64'(m_lock));
    if (m_lock != 0) check("owner", 64'(atomic_owner), 64'(m_owner));
  endtask

  initial begin
    logic [3:0] g;
    for (int i = 0; i < 4; i++) begin
      data_w[i] = 32'h1000_0000 + 32'(i);
      id_w[i]   = 8'(8'h10 + i);
    end

    do_reset();

    // Req 0 and 2 contend from rr_ptr 0
    txn(4'b0101, 0, 3'd2, 4'd14, g);
    check("g039_first", 64'(g), 64'(4'b0001));
    txn(4'b0101, 0, 3'd2, 4'd14, g);
    check("g039_second", 64'(g), 64'(4'b0100));

    // All four contend: strict rotation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      txn(4'b1111, i % 3, 3'(i), 4'(i + 3), g);
      check("g040_order", 64'(g), 64'(1) << (i % 4));
    end

    // Lock acquire, hold, re-acquire by owner, release
    do_reset();
    data_w[1] = 32'hF000_0001;
    txn(4'b0010, 1, 3'd1, 4'd5, g);
    check("lock_acq_owner", 64'(atomic_owner), 64'(1));
    data_w[1] = 32'h1234_5678;
    txn(4'b1011, 0, 3'd3, 4'd7, g);
    check("lock_starve_a", 64'(g), 64'(4'b0010));
    data_w[1] = 32'hF000_0002;
    txn(4'b1011, 2, 3'd4, 4'd8, g);
    check("lock_starve_b", 64'(g), 64'(4'b0010));
    check("lock_kept", 64'(atomic_owner_valid), 64'(1));
    txn(4'b1001, 0, 3'd0, 4'd0, g);
    check("lock_blocked", 64'(g), 64'(0));
    data_w[1] = 32'h9000_0000;
    txn(4'b1011, 0, 3'd5, 4'd9, g);
    check("lock_release_grant", 64'(g), 64'(4'b0010));
    check("lock_released", 64'(atomic_owner_valid), 64'(0));
    txn(4'b0011, 0, 3'd2, 4'd1, g);
    check("after_release", 64'(g), 64'(4'b0001));

    // Hang, tie at the last wait cycle, and release on timeout
    data_w[0] = 32'h0000_0042;
    txn(4'b0001, 100, 3'd3, 4'd3, g);
    txn(4'b0100, TO - 1, 3'd5, 4'd11, g);
    data_w[3] = 32'hF000_0003;
    txn(4'b1000, 100, 3'd1, 4'd1, g);
    check("no_acq_on_timeout", 64'(atomic_owner_valid), 64'(0));
    txn(4'b1000, 0, 3'd1, 4'd1, g);
    data_w[3] = 32'h9000_0003;
    txn(4'b1000, 100, 3'd1, 4'd1, g);
    check("release_on_timeout", 64'(atomic_owner_valid), 64'(0));

    // Classifier pulse while idle is ignored
    req_valid = '0;
    eng_classified = 1'b1;
    #1;
    check("idle_cls_rsp", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    eng_classified = 1'b0;
    #1;
    check("idle_cls_busy", 64'(busy), 64'(0));
    check("idle_cls_rsp2", 64'(rsp_valid), 64'(0));

    // Reset during WAIT with the lock held
    data_w[2] = 32'hF000_0000;
    txn(4'b0100, 0, 3'd2, 4'd2, g);
    check("mid_lock_held", 64'(atomic_owner_valid), 64'(1));
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    check("mid_busy_wait", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_owner", 64'(atomic_owner_valid), 64'(0));
    check("mid_rst_rsp", 64'(rsp_valid), 64'(0));
    m_rr = 0; m_lock = 0; m_owner = 0;
    @(negedge clk); #1;
    check("mid_rst_rsp2", 64'(rsp_valid), 64'(0));
    check("mid_rst_busy2", 64'(busy), 64'(0));

    // Randomized traffic against the model
    for (int n = 0; n < 50; n++) begin
      for (int i = 0; i < 4; i++) begin
        data_w[i] = rand_data();
        id_w[i]   = 8'($urandom);
      end
      txn(4'($urandom_range(1, 15)), $urandom_range(0, 20), 3'($urandom), 4'($urandom), g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
